// File: rtl/bp_me_dram_stream_responder_pkg.sv
// Shared configuration, BedRock DRAM message types and header layout.
package bp_me_dram_stream_responder_pkg;

    localparam int unsigned paddr_width_p     = 40;
    localparam int unsigned dword_width_p     = 64;
    localparam int unsigned cce_block_width_p = 512;
    localparam int unsigned lce_id_width_p    = 4;
    localparam int unsigned lce_assoc_p       = 8;

    localparam int unsigned block_beats_lp    = cce_block_width_p / dword_width_p;
    localparam int unsigned lg_block_beats_lp = $clog2(block_beats_lp);
    localparam int unsigned way_id_width_lp   = $clog2(lce_assoc_p);

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    // Message size is 2^size bytes
    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [way_id_width_lp-1:0] way_id;
        logic [lce_id_width_p-1:0]  lce_id;
    } bp_bedrock_dram_mem_payload_s;

    typedef struct packed {
        bp_bedrock_dram_mem_payload_s payload;
        bp_bedrock_msg_size_e         size;
        logic [paddr_width_p-1:0]     addr;
        bp_bedrock_mem_type_e         msg_type;
    } bp_bedrock_dram_mem_msg_header_s;

    localparam int unsigned bp_bedrock_dram_mem_msg_header_width_lp =
        $bits(bp_bedrock_dram_mem_msg_header_s);

endpackage

// File: rtl/bp_me_dram_stream_responder_if.sv
// Streamed BedRock memory command/response channels between L2 DMA and DRAM.
interface bp_me_dram_stream_responder_if;
    import bp_me_dram_stream_responder_pkg::*;

    bp_bedrock_dram_mem_msg_header_s mem_cmd_header_i;
    logic                            mem_cmd_header_v_i;
    logic                            mem_cmd_header_yumi_o;
    logic [dword_width_p-1:0]        mem_cmd_data_i;
    logic                            mem_cmd_data_v_i;
    logic                            mem_cmd_data_yumi_o;

    bp_bedrock_dram_mem_msg_header_s mem_resp_header_o;
    logic                            mem_resp_header_v_o;
    logic                            mem_resp_header_ready_i;
    logic [dword_width_p-1:0]        mem_resp_data_o;
    logic                            mem_resp_data_v_o;
    logic                            mem_resp_data_ready_i;

    // Requester side (L2 DMA port)
    modport master (
        output mem_cmd_header_i, mem_cmd_header_v_i, mem_cmd_data_i, mem_cmd_data_v_i,
        output mem_resp_header_ready_i, mem_resp_data_ready_i,
        input  mem_cmd_header_yumi_o, mem_cmd_data_yumi_o,
        input  mem_resp_header_o, mem_resp_header_v_o, mem_resp_data_o, mem_resp_data_v_o
    );

    // Responder side (DRAM)
    modport slave (
        input  mem_cmd_header_i, mem_cmd_header_v_i, mem_cmd_data_i, mem_cmd_data_v_i,
        input  mem_resp_header_ready_i, mem_resp_data_ready_i,
        output mem_cmd_header_yumi_o, mem_cmd_data_yumi_o,
        output mem_resp_header_o, mem_resp_header_v_o, mem_resp_data_o, mem_resp_data_v_o
    );

endinterface

// File: rtl/bp_me_dram_stream_responder_mem.sv
// Backing store: one async read port, one synchronous write port, no reset.
module bsg_mem_1r1w #(
    parameter int unsigned width_p = 64,
    parameter int unsigned els_p   = 1024,
    localparam int unsigned addr_width_lp = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // Write port
    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_me_dram_stream_responder.sv
// DRAM-side responder for streamed BedRock block reads/writes, one command at a time.
module bp_me_dram_stream_responder
    import bp_me_dram_stream_responder_pkg::*;
#(
    parameter int unsigned mem_els_p = 1024
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    bp_me_dram_stream_responder_if.slave  bus
);

    localparam int unsigned lg_mem_els_lp = $clog2(mem_els_p);
    localparam int unsigned cnt_width_lp  = lg_block_beats_lp + 1;

    typedef enum logic [2:0] {
        e_idle, e_wr_data, e_wr_resp, e_rd_resp, e_rd_data
    } state_e;

    state_e                          state_q, state_d;
    logic [cnt_width_lp-1:0]         cnt_q, cnt_d;
    bp_bedrock_dram_mem_msg_header_s hdr_q, hdr_d;

    logic [cnt_width_lp-1:0]         lg_n;
    logic [cnt_width_lp-1:0]         last_cnt;
    logic [lg_mem_els_lp-1:0]        idx_mask;
    logic [lg_mem_els_lp-1:0]        dw_addr;
    logic [lg_mem_els_lp-1:0]        word_idx;
    logic                            mem_w_v;
    logic [dword_width_p-1:0]        mem_r_data;

    // Beat count log2: bytes/8, at least one beat, at most a full block
    always_comb begin
        lg_n = '0;
        if (hdr_q.size > 3'd3) begin
            lg_n = cnt_width_lp'(hdr_q.size - 3'd3);
        end
        if (lg_n > cnt_width_lp'(lg_block_beats_lp)) begin
            lg_n = cnt_width_lp'(lg_block_beats_lp);
        end
    end

    // Critical-word-first index wrapping within the size-aligned region
    always_comb begin
        last_cnt = cnt_width_lp'((cnt_width_lp'(1) << lg_n) - cnt_width_lp'(1));
        idx_mask = lg_mem_els_lp'((lg_mem_els_lp'(1) << lg_n) - lg_mem_els_lp'(1));
        dw_addr  = hdr_q.addr[3 +: lg_mem_els_lp];
        word_idx = (dw_addr & ~idx_mask)
                 | ((dw_addr + lg_mem_els_lp'(cnt_q)) & idx_mask);
    end

    // State, beat counter and captured header
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            cnt_q   <= '0;
            hdr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
        end
    end

    // Next-state, counter and header capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        unique case (state_q)
            e_idle: begin
                if (bus.mem_cmd_header_v_i) begin
                    hdr_d = bus.mem_cmd_header_i;
                    cnt_d = '0;
                    if ((bus.mem_cmd_header_i.msg_type == e_bedrock_mem_wr)
                        || (bus.mem_cmd_header_i.msg_type == e_bedrock_mem_uc_wr)) begin
                        state_d = e_wr_data;
                    end else begin
                        state_d = e_rd_resp;
                    end
                end
            end
            e_wr_data: begin
                if (bus.mem_cmd_data_v_i) begin
                    cnt_d = cnt_q + cnt_width_lp'(1);
                    if (cnt_q == last_cnt) begin
                        state_d = e_wr_resp;
                    end
                end
            end
            e_wr_resp: begin
                if (bus.mem_resp_header_ready_i) begin
                    state_d = e_idle;
                end
            end
            e_rd_resp: begin
                if (bus.mem_resp_header_ready_i) begin
                    state_d = e_rd_data;
                end
            end
            e_rd_data: begin
                if (bus.mem_resp_data_ready_i) begin
                    cnt_d = cnt_q + cnt_width_lp'(1);
                    if (cnt_q == last_cnt) begin
                        state_d = e_idle;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // Handshake outputs, store write strobe and response payloads
    always_comb begin
        bus.mem_cmd_header_yumi_o = 1'b0;
        bus.mem_cmd_data_yumi_o   = 1'b0;
        bus.mem_resp_header_v_o   = 1'b0;
        bus.mem_resp_data_v_o     = 1'b0;
        bus.mem_resp_header_o     = hdr_q;
        bus.mem_resp_data_o       = mem_r_data;
        mem_w_v                   = 1'b0;
        unique case (state_q)
            e_idle:    bus.mem_cmd_header_yumi_o = bus.mem_cmd_header_v_i;
            e_wr_data: begin
                bus.mem_cmd_data_yumi_o = bus.mem_cmd_data_v_i;
                mem_w_v                 = bus.mem_cmd_data_v_i;
            end
            e_wr_resp: bus.mem_resp_header_v_o = 1'b1;
            e_rd_resp: bus.mem_resp_header_v_o = 1'b1;
            e_rd_data: bus.mem_resp_data_v_o   = 1'b1;
            default: ;
        endcase
    end

    bsg_mem_1r1w #(
        .width_p (dword_width_p),
        .els_p   (mem_els_p)
    ) store (
        .w_clk_i  (clk_i),
        .w_v_i    (mem_w_v),
        .w_addr_i (word_idx),
        .w_data_i (bus.mem_cmd_data_i),
        .r_addr_i (word_idx),
        .r_data_o (mem_r_data)
    );

endmodule

// File: tb/tb_bp_me_dram_stream_responder.sv
// Directed scoreboard bench for the DRAM stream responder.
module tb_bp_me_dram_stream_responder;
    import bp_me_dram_stream_responder_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bp_me_dram_stream_responder_if bus ();

    bp_me_dram_stream_responder #(.mem_els_p(1024)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0]                     mdl [1024];
    logic [63:0]                     exp_data_q [$];
    bp_bedrock_dram_mem_msg_header_s exp_hdr_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbeats(input bp_bedrock_msg_size_e sz);
        int n;
        n = (int'(sz) <= 3) ? 1 : (1 << (int'(sz) - 3));
        if (n > 8) n = 8;
        return n;
    endfunction

    function automatic int unsigned midx(input logic [39:0] a, input bp_bedrock_msg_size_e sz, input int k);
        int unsigned n, dw, base;
        n    = int'(nbeats(sz));
        dw   = 32'(a >> 3);
        base = dw - (dw % n);
        return (base + ((dw % n) + k) % n) % 1024;
    endfunction

    function automatic bp_bedrock_dram_mem_msg_header_s mkhdr(
        input bp_bedrock_mem_type_e mt, input bp_bedrock_msg_size_e sz, input logic [39:0] a);
        bp_bedrock_dram_mem_msg_header_s h;
        h.msg_type       = mt;
        h.size           = sz;
        h.addr           = a;
        h.payload.lce_id = 4'h5;
        h.payload.way_id = 3'h2;
        return h;
    endfunction

    // One full command: optional early data, header, write beats, response header, read beats
    task automatic run_cmd(input bp_bedrock_mem_type_e mt, input bp_bedrock_msg_size_e sz,
                           input logic [39:0] addr, input logic [63:0] wd [8],
                           input bit rnd, input int early, input int abort_after);
        bp_bedrock_dram_mem_msg_header_s h, prev_h;
        logic [63:0] prev_d;
        bit is_wr, seen, pend, first;
        int n, k, budget;
        h     = mkhdr(mt, sz, addr);
        is_wr = (mt == e_bedrock_mem_wr) || (mt == e_bedrock_mem_uc_wr);
        n     = nbeats(sz);

        if (is_wr && early > 0) begin
            bus.mem_cmd_data_v_i = 1'b1;
            bus.mem_cmd_data_i   = wd[0];
            repeat (early) begin
                @(negedge clk);
                chk("early_yumi", 128'(bus.mem_cmd_data_yumi_o), 128'(0));
                next_cycle();
            end
        end

        bus.mem_cmd_header_i   = h;
        bus.mem_cmd_header_v_i = 1'b1;
        @(negedge clk);
        chk("hdr_yumi", 128'(bus.mem_cmd_header_yumi_o), 128'(1));
        chk("idle_no_rdata", 128'(bus.mem_resp_data_v_o), 128'(0));
        if (is_wr && early > 0) chk("early_yumi_cap", 128'(bus.mem_cmd_data_yumi_o), 128'(0));
        next_cycle();
        bus.mem_cmd_header_v_i = 1'b0;

        if (!is_wr) begin
            for (int i = 0; i < n; i++) exp_data_q.push_back(mdl[midx(addr, sz, i)]);
        end

        if (is_wr) begin
            k = 0;
            budget = 200;
            while (k < n && budget > 0) begin
                bus.mem_cmd_data_v_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.mem_cmd_data_i   = wd[k];
                @(negedge clk);
                chk("wr_yumi", 128'(bus.mem_cmd_data_yumi_o), 128'(bus.mem_cmd_data_v_i));
                if (bus.mem_cmd_data_v_i && bus.mem_cmd_data_yumi_o) begin
                    mdl[midx(addr, sz, k)] = wd[k];
                    k++;
                end
                next_cycle();
                budget--;
                if (abort_after > 0 && k == abort_after) begin
                    bus.mem_cmd_data_v_i = 1'b0;
                    reset = 1'b1;
                    next_cycle();
                    reset = 1'b0;
                    bus.mem_cmd_data_v_i = 1'b1;
                    bus.mem_cmd_data_i   = wd[k];
                    @(negedge clk);
                    chk("rst_data_yumi", 128'(bus.mem_cmd_data_yumi_o), 128'(0));
                    chk("rst_hdr_yumi", 128'(bus.mem_cmd_header_yumi_o), 128'(0));
                    chk("rst_hdr_v", 128'(bus.mem_resp_header_v_o), 128'(0));
                    chk("rst_data_v", 128'(bus.mem_resp_data_v_o), 128'(0));
                    next_cycle();
                    bus.mem_cmd_data_v_i = 1'b0;
                    return;
                end
            end
            if (k < n) chk("wr_timeout", 128'(k), 128'(n));
            bus.mem_cmd_data_v_i = 1'b0;
        end

        exp_hdr_q.push_back(h);
        seen = 1'b0; pend = 1'b0; first = 1'b1; budget = 200;
        while (!seen && budget > 0) begin
            bus.mem_resp_header_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (first && !rnd) chk("rsp_hdr_lat", 128'(bus.mem_resp_header_v_o), 128'(1));
            if (pend) begin
                chk("hdr_hold_v", 128'(bus.mem_resp_header_v_o), 128'(1));
                chk("hdr_hold", 128'(bus.mem_resp_header_o), 128'(prev_h));
            end
            if (bus.mem_resp_header_v_o) begin
                if (bus.mem_resp_header_ready_i) begin
                    chk("rsp_hdr", 128'(bus.mem_resp_header_o), 128'(exp_hdr_q.pop_front()));
                    seen = 1'b1;
                end else begin
                    pend   = 1'b1;
                    prev_h = bus.mem_resp_header_o;
                end
            end
            next_cycle();
            first = 1'b0;
            budget--;
        end
        if (!seen) begin
            chk("rsp_hdr_timeout", 128'(0), 128'(1));
            exp_hdr_q.delete();
        end
        bus.mem_resp_header_ready_i = 1'b0;

        if (!is_wr) begin
            pend = 1'b0; first = 1'b1; budget = 300;
            while (exp_data_q.size() > 0 && budget > 0) begin
                bus.mem_resp_data_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (first && !rnd) chk("rd_data_lat", 128'(bus.mem_resp_data_v_o), 128'(1));
                if (pend) begin
                    chk("data_hold_v", 128'(bus.mem_resp_data_v_o), 128'(1));
                    chk("data_hold", 128'(bus.mem_resp_data_o), 128'(prev_d));
                end
                if (bus.mem_resp_data_v_o && bus.mem_resp_data_ready_i) begin
                    chk("rd_data", 128'(bus.mem_resp_data_o), 128'(exp_data_q.pop_front()));
                    pend = 1'b0;
                end else if (bus.mem_resp_data_v_o) begin
                    pend   = 1'b1;
                    prev_d = bus.mem_resp_data_o;
                end
                next_cycle();
                first = 1'b0;
                budget--;
            end
            if (exp_data_q.size() > 0) begin
                chk("rd_timeout", 128'(exp_data_q.size()), 128'(0));
                exp_data_q.delete();
            end
            bus.mem_resp_data_ready_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] wd_a [8];
        logic [63:0] wd_b [8];
        logic [63:0] wd_c [8];
        logic [63:0] wd_d [8];
        logic [63:0] wd_z [8];

        for (int i = 0; i < 8; i++) begin
            wd_a[i] = 64'(i);
            wd_b[i] = 64'h100 + 64'(i);
            wd_c[i] = {$urandom, $urandom};
            wd_d[i] = 64'h0;
            wd_z[i] = 64'h0;
        end
        wd_d[0] = 64'hDEAD;

        bus.mem_cmd_header_i        = '0;
        bus.mem_cmd_header_v_i      = 1'b0;
        bus.mem_cmd_data_i          = '0;
        bus.mem_cmd_data_v_i        = 1'b0;
        bus.mem_resp_header_ready_i = 1'b0;
        bus.mem_resp_data_ready_i   = 1'b0;

        // Reset state, with a stray data beat offered
        reset = 1'b1;
        repeat (3) next_cycle();
        bus.mem_cmd_data_v_i = 1'b1;
        @(negedge clk);
        chk("rst_hdr_v", 128'(bus.mem_resp_header_v_o), 128'(0));
        chk("rst_data_v", 128'(bus.mem_resp_data_v_o), 128'(0));
        chk("rst_data_yumi", 128'(bus.mem_cmd_data_yumi_o), 128'(0));
        chk("rst_hdr_yumi", 128'(bus.mem_cmd_header_yumi_o), 128'(0));
        next_cycle();
        reset = 1'b0;
        bus.mem_cmd_data_v_i = 1'b0;
        next_cycle();

        // Block write then read back, then critical-word-first read
        run_cmd(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h1000, wd_a, 1'b0, 0, 0);
        run_cmd(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1000, wd_z, 1'b0, 0, 0);
        run_cmd(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1018, wd_z, 1'b0, 0, 0);

        // Oversized request clamps to one block
        run_cmd(e_bedrock_mem_rd, e_bedrock_msg_size_128, 40'h1008, wd_z, 1'b0, 0, 0);

        // Random backpressure on both response channels
        run_cmd(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1000, wd_z, 1'b1, 0, 0);

        // Write data offered before its header, then randomised read-back
        run_cmd(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h3000, wd_c, 1'b0, 3, 0);
        run_cmd(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h3020, wd_z, 1'b1, 0, 0);

        // Single-beat uncached write and read
        run_cmd(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h2008, wd_d, 1'b0, 0, 0);
        run_cmd(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h2008, wd_z, 1'b0, 0, 0);

        // Random write valid, then two-beat read with wrap
        run_cmd(e_bedrock_mem_wr, e_bedrock_msg_size_16, 40'h2010, wd_b, 1'b1, 0, 0);
        run_cmd(e_bedrock_mem_rd, e_bedrock_msg_size_16, 40'h2018, wd_z, 1'b0, 0, 0);

        // Reset after four beats; block keeps the four new words and prior tail
        run_cmd(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h1000, wd_b, 1'b0, 0, 4);
        run_cmd(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h1000, wd_z, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
